// File: rtl/slave_responder.sv
// Two-wire bus slave: receives written bytes and returns i_tx_data on reads at address SLAVE_ADDR.
// Latency: bus edges are seen 3 i_clk after they occur; o_rx_valid 1 i_clk after the 8th sampling edge.
// Backpressure: none; the master owns SCL, the block never stretches it, and data is taken or offered on the bus timing.
module slave_responder #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1100110
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_scl,
   inout  wire        io_sda,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_load,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
   } state_t;

   logic scl_meta, scl_s, scl_d;
   logic sda_meta, sda_s, sda_d;

   state_t     state, state_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] rx_shift, rx_shift_nxt;
   logic [7:0] tx_shift, tx_shift_nxt;
   logic       sda_low, sda_low_nxt;
   logic       rw, rw_nxt;
   logic [7:0] rx_data, rx_data_nxt;
   logic       rx_valid_nxt, tx_load_nxt;
   logic       rx_valid, tx_load;

   logic scl_rise, scl_fall, start_det, stop_det;

   // Two-flop synchronizers plus a delayed copy for edge detection; idle bus is high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scl_meta <= 1'b1;
         scl_s    <= 1'b1;
         scl_d    <= 1'b1;
         sda_meta <= 1'b1;
         sda_s    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_meta <= i_scl;
         scl_s    <= scl_meta;
         scl_d    <= scl_s;
         sda_meta <= io_sda;
         sda_s    <= sda_meta;
         sda_d    <= sda_s;
      end
   end

   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = sda_d & ~sda_s & scl_s;
   assign stop_det  = ~sda_d & sda_s & scl_s;

   // Open drain: only ever pull low; reset releases the line combinationally.
   assign io_sda = (sda_low && i_rst_n) ? 1'b0 : 1'bz;

   assign o_rx_data  = rx_data;
   assign o_rx_valid = rx_valid;
   assign o_tx_load  = tx_load;
   assign o_busy     = (state != IDLE);

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         bit_cnt  <= 3'd0;
         rx_shift <= 8'h00;
         tx_shift <= 8'h00;
         sda_low  <= 1'b0;
         rw       <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         tx_load  <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         rx_shift <= rx_shift_nxt;
         tx_shift <= tx_shift_nxt;
         sda_low  <= sda_low_nxt;
         rw       <= rw_nxt;
         rx_data  <= rx_data_nxt;
         rx_valid <= rx_valid_nxt;
         tx_load  <= tx_load_nxt;
      end
   end

   // Next-state and datapath updates; START outranks STOP and any SCL edge.
   // In the ACK states sda_low doubles as "first fall already seen".
   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      rx_shift_nxt = rx_shift;
      tx_shift_nxt = tx_shift;
      sda_low_nxt  = sda_low;
      rw_nxt       = rw;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = 1'b0;
      tx_load_nxt  = 1'b0;
      if (start_det) begin
         state_nxt   = ADDR;
         bit_cnt_nxt = 3'd0;
         sda_low_nxt = 1'b0;
      end else if (stop_det) begin
         state_nxt   = IDLE;
         sda_low_nxt = 1'b0;
      end else begin
         case (state)
            IDLE, WAIT_STOP: ;
            ADDR: begin
               if (scl_rise) begin
                  rx_shift_nxt = {rx_shift[6:0], sda_s};
                  bit_cnt_nxt  = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rw_nxt    = sda_s;
                     state_nxt = (rx_shift[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_low) begin
                     sda_low_nxt = 1'b1;
                  end else begin
                     bit_cnt_nxt = 3'd0;
                     if (rw) begin
                        // First read bit goes out on this fall; the shifter holds the rest.
                        tx_shift_nxt = {i_tx_data[6:0], 1'b0};
                        sda_low_nxt  = ~i_tx_data[7];
                        tx_load_nxt  = 1'b1;
                        state_nxt    = TX_DATA;
                     end else begin
                        sda_low_nxt = 1'b0;
                        state_nxt   = RX_DATA;
                     end
                  end
               end
            end
            RX_DATA: begin
               if (scl_rise) begin
                  rx_shift_nxt = {rx_shift[6:0], sda_s};
                  bit_cnt_nxt  = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rx_data_nxt  = {rx_shift[6:0], sda_s};
                     rx_valid_nxt = 1'b1;
                     state_nxt    = RX_ACK;
                  end
               end
            end
            RX_ACK: begin
               if (scl_fall) begin
                  if (!sda_low) begin
                     sda_low_nxt = 1'b1;
                  end else begin
                     sda_low_nxt = 1'b0;
                     state_nxt   = RX_DATA;
                  end
               end
            end
            TX_DATA: begin
               if (scl_rise) begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state_nxt = TX_ACK;
               end else if (scl_fall) begin
                  sda_low_nxt  = ~tx_shift[7];
                  tx_shift_nxt = {tx_shift[6:0], 1'b0};
               end
            end
            TX_ACK: begin
               if (scl_fall) begin
                  sda_low_nxt = 1'b0;
               end else if (scl_rise) begin
                  if (!sda_s) begin
                     // Reloaded byte is presented MSB first from the next fall.
                     tx_shift_nxt = i_tx_data;
                     tx_load_nxt  = 1'b1;
                     bit_cnt_nxt  = 3'd0;
                     state_nxt    = TX_DATA;
                  end else begin
                     state_nxt = WAIT_STOP;
                  end
               end
            end
            default: begin
               state_nxt   = IDLE;
               sda_low_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/slave_responder.md
SLAVE_RESPONDER -- requirements
Module: slave_responder

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'b1100110, the 7-bit bus address it responds to.
REQ-002 The block SHALL have port i_clk, input, 1, the single system clock; all logic SHALL be synchronous to its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port i_scl, input, 1, the bus clock, which is asynchronous to i_clk.
REQ-005 The block SHALL have port io_sda, inout, 1, the open-drain bus data line: driven 0 or high-Z, never driven 1.
REQ-006 The block SHALL have port i_tx_data, input, 8, the byte returned to the master during a read.
REQ-007 The block SHALL have port o_tx_load, output, 1, a one-cycle pulse when i_tx_data is captured into the transmit shifter.
REQ-008 The block SHALL have port o_rx_data, output, 8, the last byte written by the master.
REQ-009 The block SHALL have port o_rx_valid, output, 1, a one-cycle pulse when o_rx_data is updated.
REQ-010 The block SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 i_scl and io_sda SHALL each pass through a 2-flop synchronizer; edges SHALL be detected from the synchronized value and its one-cycle-delayed copy.
REQ-012 START SHALL be a synchronized SDA fall while synchronized SCL is high; STOP SHALL be a synchronized SDA rise while SCL is high.
REQ-013 The FSM SHALL have exactly these states: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
REQ-014 Bits SHALL be sampled on the SCL rising edge, MSB first; the block SHALL change its io_sda drive only on the SCL falling edge.
REQ-015 In ADDR the block SHALL shift 8 bits (7 address bits, then R/W); a 3-bit counter SHALL count 0-7 and wrap to 0.
REQ-016 On an address match, at the SCL fall after bit 8 the block SHALL drive SDA low (ACK) for ADDR_ACK, and release it at the next SCL fall.
REQ-017 On an address mismatch the block SHALL leave SDA released and go to WAIT_STOP, ignoring all traffic until the next START or STOP.
REQ-018 If R/W=0 after ADDR_ACK, the FSM SHALL go to RX_DATA; after 8 bits it SHALL update o_rx_data and pulse o_rx_valid one i_clk after the 8th sampling edge, then ACK in RX_ACK and return to RX_DATA.
REQ-019 If R/W=1, at the SCL fall ending ADDR_ACK the block SHALL load i_tx_data, pulse o_tx_load, and drive bit 7 (SDA low for 0, high-Z for 1).
REQ-020 In TX_DATA the block SHALL present the remaining bits on successive SCL falls, then release SDA for TX_ACK.
REQ-021 In TX_ACK the block SHALL sample the master bit on SCL rise: a 0 (ACK) SHALL reload i_tx_data and re-enter TX_DATA; a 1 (NACK) SHALL go to WAIT_STOP.
REQ-022 A START detected in any state, including a repeated START, SHALL clear the bit counter, release SDA and enter ADDR.
REQ-023 A STOP detected in any state, including mid-byte, SHALL release SDA and enter IDLE; a partial byte SHALL be discarded with no o_rx_valid pulse.
REQ-024 If START and an SCL edge are detected in the same i_clk cycle, START SHALL take priority.
REQ-025 START/STOP detection latency SHALL be 3 i_clk cycles from the bus edge (2 synchronizer cycles plus 1 edge cycle).

Reset
REQ-026 While i_rst_n=0 the block SHALL immediately put the FSM in IDLE and release io_sda to Z, even mid-ACK or mid-transmit.
REQ-027 During reset the block SHALL hold o_rx_data=8'h00, o_rx_valid=0, o_tx_load=0, o_busy=0, the counter and shifters at 0, and the synchronizers at 1 (idle bus).
REQ-028 After i_rst_n rises, the block SHALL ignore the bus until it detects a START.

Verification
REQ-029 Write test: START, 0xCC (addr 0x66, W), 0xA5, STOP -> SDA low on both 9th clocks, o_rx_data=0xA5 with one o_rx_valid pulse, o_busy returns to 0 after STOP.
REQ-030 Read test: START, 0xCD, i_tx_data=0xE3, master NACK, STOP -> SDA reads 1,1,1,0,0,0,1,1 on SCL highs, one o_tx_load pulse, FSM goes to WAIT_STOP then IDLE.
REQ-031 Multi-byte read test: i_tx_data=0x3C then 0x81 with a master ACK between them -> two o_tx_load pulses and both bytes transmitted intact.
REQ-032 Address mismatch test: START, 0xAA -> SDA never driven low, no o_rx_valid, following data bytes ignored until STOP.
REQ-033 Repeated START test: a write of 0xCC followed by a repeated START and 0xCD -> ACK both addresses, then transmit i_tx_data.
REQ-034 Abort test: i_rst_n pulled low while driving ACK -> io_sda=Z within the same cycle; STOP after 4 data bits -> IDLE with no o_rx_valid pulse.
